// File: rtl/end_text_controller.sv
// ---------------------------------------------------------------------------
// end_text_controller
//
// Sequences the end-of-game text overlay ("YOU WON" / "YOU LOST") for the
// 2048 VGA path.
//
// The game result is latched only at frame boundaries, so a message never
// tears in the middle of a frame. A frame-based timer blinks the text. The
// current pixel is mapped to a character slot, and one shared display_char
// instance is fed with a registered char code, an enable and the aligned
// pixel coordinates.
//
// Ports
//   clk            pixel clock
//   rst            asynchronous active-low reset
//   frame_start    one-cycle pulse at the start of vertical blank
//   game_won       level, board reached 2048
//   game_lost      level, no moves remain
//   new_game       one-cycle pulse, request to clear the overlay
//   x, y           current pixel column / row
//   char_code      ASCII code for the shared display_char (0 when disabled)
//   char_en        enable for the shared display_char
//   x_out, y_out   x / y delayed by one cycle to align with char_code
//   overlay_active high in WIN or LOSE
//   msg_state      0 = IDLE, 1 = WIN, 2 = LOSE
//
// State   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no overlay; waits for a result at a frame_start
// WIN     | "YOU WON" shown and blinking; leaves at frame_start if cleared
// LOSE    | "YOU LOST" shown and blinking; leaves at frame_start if cleared
// ---------------------------------------------------------------------------
module end_text_controller #(
  parameter int TEXT_X0      = 0,
  parameter int TEXT_Y0      = 16,
  parameter int N_SLOTS      = 8,
  parameter int BLINK_FRAMES = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_start,
  input  logic       game_won,
  input  logic       game_lost,
  input  logic       new_game,
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic [7:0] char_code,
  output logic       char_en,
  output logic [9:0] x_out,
  output logic [9:0] y_out,
  output logic       overlay_active,
  output logic [1:0] msg_state
);

  localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_FRAMES - 1);

  // The band limits are held one bit wider than the pixel coordinates so
  // that the upper limits cannot wrap.
  localparam logic [10:0] X_LO = 11'(TEXT_X0);
  localparam logic [10:0] X_HI = 11'(TEXT_X0 + 8 * N_SLOTS);
  localparam logic [10:0] Y_LO = 11'(TEXT_Y0);
  localparam logic [10:0] Y_HI = 11'(TEXT_Y0 + 8);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WIN  = 2'd1,
    LOSE = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic          clear_pend, clear_pend_nxt;
  logic [CW-1:0] frame_cnt, frame_cnt_nxt;
  logic          visible, visible_nxt;

  // Message table. A returned value of 0 means the slot is blank.
  function automatic logic [7:0] msg_char(input logic lose, input logic [7:0] slot);
    logic [7:0] c;
    case (slot)
      8'd0:    c = 8'd89;                    // Y
      8'd1:    c = 8'd79;                    // O
      8'd2:    c = 8'd85;                    // U
      8'd4:    c = lose ? 8'd76 : 8'd87;     // L / W
      8'd5:    c = 8'd79;                    // O
      8'd6:    c = lose ? 8'd83 : 8'd78;     // S / N
      8'd7:    c = lose ? 8'd84 : 8'd0;      // T / blank
      default: c = 8'd0;
    endcase
    return c;
  endfunction

  // ------------------------------------------------------------------
  // Message FSM and blink timer
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      clear_pend <= 1'b0;
      frame_cnt  <= '0;
      visible    <= 1'b1;
    end else begin
      state      <= state_nxt;
      clear_pend <= clear_pend_nxt;
      frame_cnt  <= frame_cnt_nxt;
      visible    <= visible_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    clear_pend_nxt = clear_pend;
    frame_cnt_nxt  = frame_cnt;
    visible_nxt    = visible;

    case (state)
      IDLE: begin
        clear_pend_nxt = 1'b0;
        if (frame_start) begin
          if (game_won) begin
            state_nxt     = WIN;
            frame_cnt_nxt = '0;
            visible_nxt   = 1'b1;
          end else if (game_lost) begin
            state_nxt     = LOSE;
            frame_cnt_nxt = '0;
            visible_nxt   = 1'b1;
          end
        end
      end

      WIN, LOSE: begin
        // A new_game that lands on the frame_start itself clears the
        // overlay at that same boundary. It is not held off to the next one.
        if (frame_start && (clear_pend || new_game)) begin
          state_nxt      = IDLE;
          clear_pend_nxt = 1'b0;
        end else begin
          if (new_game) begin
            clear_pend_nxt = 1'b1;
          end
          if (frame_start) begin
            if (frame_cnt == CNT_LAST) begin
              frame_cnt_nxt = '0;
              visible_nxt   = ~visible;
            end else begin
              frame_cnt_nxt = frame_cnt + CW'(1);
            end
          end
        end
      end

      default: begin
        state_nxt      = IDLE;
        clear_pend_nxt = 1'b0;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Pixel to slot mapping
  // ------------------------------------------------------------------
  logic [10:0] x_ext, y_ext, dx;
  logic [7:0]  slot;
  logic [7:0]  glyph;
  logic        in_band;
  logic        pix_en;

  assign x_ext = {1'b0, x};
  assign y_ext = {1'b0, y};

  // dx can wrap when x < TEXT_X0. The in_band term masks that case, so the
  // wrapped slot never reaches the output.
  assign dx      = x_ext - X_LO;
  assign slot    = 8'(dx >> 3);
  assign in_band = (y_ext >= Y_LO) && (y_ext < Y_HI) &&
                   (x_ext >= X_LO) && (x_ext < X_HI);

  assign glyph  = msg_char(state == LOSE, slot);
  assign pix_en = in_band && visible && (state != IDLE) && (glyph != 8'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      char_en   <= 1'b0;
      char_code <= 8'd0;
      x_out     <= 10'd0;
      y_out     <= 10'd0;
    end else begin
      char_en   <= pix_en;
      char_code <= pix_en ? glyph : 8'd0;
      x_out     <= x;
      y_out     <= y;
    end
  end

  assign msg_state      = state;
  assign overlay_active = (state != IDLE);

endmodule
